// File: rtl/mul_seq.sv
// Iterative shift-add unsigned multiplier: N x N -> 2N product using one 2N-bit adder.
// Latency: start accepted at edge E0, done/mul_rd visible N cycles later; one op every N+1 cycles.
// Backpressure: busy=1 while running; start is ignored (not queued) while busy; abort cancels.
//
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   start         - request, sampled only when not busy (IDLE or DONE)
//   abort         - cancel in-flight operation, ignored unless busy
//   rs1, rs2      - multiplicand / multiplier, latched on accepted start
//   busy          - high while the operation is running
//   done          - one-cycle pulse when mul_rd has just been updated
//   mul_rd        - product, held stable between updates
module mul_seq #(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N-1:0]     rs1,
    input  logic [N-1:0]     rs2,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   mul_rd
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*N-1:0]   a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   mul_rd_q, mul_rd_d;

    // Partial sum for this step; on the last step it is the finished product.
    logic [2*N-1:0]   sum;
    assign sum = acc_q + ({(2*N){b_q[0]}} & a_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mul_rd_d = mul_rd_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = {{N{1'b0}}, rs1};
                    b_d     = rs2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Abort wins over completion, so mul_rd is never touched on an abort.
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = sum;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        mul_rd_d = sum;
                        state_d  = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mul_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mul_rd_q <= mul_rd_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign mul_rd = mul_rd_q;

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

    localparam int N = 16;

    logic            clk;
    logic            rst;
    logic            start;
    logic            abort;
    logic [N-1:0]    rs1;
    logic [N-1:0]    rs2;
    logic            busy;
    logic            done;
    logic [2*N-1:0]  mul_rd;

    int n_checks;
    int n_fail;
    int cyc;

    mul_seq #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .mul_rd (mul_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance past one rising edge and settle; all sampling and driving happens here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference product: plain unsigned arithmetic at 2N bits.
    function automatic logic [2*N-1:0] model_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] wa;
        logic [2*N-1:0] wb;
        wa = {{N{1'b0}}, a};
        wb = {{N{1'b0}}, b};
        return wa * wb;
    endfunction

    // Launch one operation and wait (bounded) for done. Returns the number of cycles
    // from acceptance to done (-1 on timeout), how many cycles busy was seen, and
    // whether mul_rd stayed unchanged until done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int nbusy, output bit stable);
        logic [2*N-1:0] prev;
        prev  = mul_rd;
        start = 1'b1;
        rs1   = a;
        rs2   = b;
        tick();
        start = 1'b0;
        rs1   = N'($urandom);
        rs2   = N'($urandom);
        lat    = -1;
        nbusy  = 0;
        stable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) nbusy++;
            if (mul_rd !== prev) stable = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++;
        if (mul_rd !== '0) begin n_fail++; $display("FAIL reset_mul_rd: got %h want 0", mul_rd); end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, nbusy, ndone;
        bit stable;
        run_op(16'd3, 16'd5, lat, nbusy, stable);
        n_checks++;
        if (lat !== N) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, N); end
        n_checks++;
        if (nbusy !== N) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", nbusy, N); end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL basic_hold_during_run: got changed want stable"); end
        n_checks++;
        if (mul_rd !== model_mul(16'd3, 16'd5)) begin
            n_fail++; $display("FAIL basic_product: got %0d want %0d", mul_rd, model_mul(16'd3, 16'd5));
        end
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin n_fail++; $display("FAIL basic_single_done: got %0d extra pulses want 0", ndone); end
        n_checks++;
        if (mul_rd !== 32'd15) begin n_fail++; $display("FAIL basic_hold_after: got %0d want 15", mul_rd); end
    endtask

    task automatic test_extremes();
        int lat, nbusy;
        bit stable;
        run_op(16'hFFFF, 16'hFFFF, lat, nbusy, stable);
        n_checks++;
        if (mul_rd !== 32'hFFFE0001) begin n_fail++; $display("FAIL max_product: got %h want fffe0001", mul_rd); end
        tick();
        run_op(16'h0000, 16'h1234, lat, nbusy, stable);
        n_checks++;
        if (mul_rd !== 32'h0) begin n_fail++; $display("FAIL zero_product: got %h want 0", mul_rd); end
        n_checks++;
        if (lat !== N) begin n_fail++; $display("FAIL zero_latency: got %0d want %0d", lat, N); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] av[3];
        logic [N-1:0] bv[3];
        logic [2*N-1:0] want[3];
        int done_cyc[3];
        int lat, nbusy;
        bit stable;
        av[0] = 16'd7;    bv[0] = 16'd9;    want[0] = 32'd63;
        av[1] = 16'h8000; bv[1] = 16'd2;    want[1] = 32'h00010000;
        av[2] = 16'd1;    bv[2] = 16'hFFFF; want[2] = 32'h0000FFFF;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], lat, nbusy, stable);
            done_cyc[i] = cyc;
            n_checks++;
            if (mul_rd !== want[i]) begin
                n_fail++; $display("FAIL b2b_product_%0d: got %h want %h", i, mul_rd, want[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (done_cyc[i] - done_cyc[i-1] !== N + 1) begin
                    n_fail++; $display("FAIL b2b_spacing_%0d: got %0d want %0d", i, done_cyc[i] - done_cyc[i-1], N + 1);
                end
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_return_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_start_while_busy();
        int ndone;
        start = 1'b1; rs1 = 16'd100; rs2 = 16'd200;
        tick();
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        start = 1'b1; rs1 = 16'd1; rs2 = 16'd1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                ndone++;
                n_checks++;
                if (mul_rd !== 32'd20000) begin n_fail++; $display("FAIL busy_start_product: got %0d want 20000", mul_rd); end
            end
            tick();
        end
        n_checks++;
        if (ndone !== 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_abort();
        int lat, nbusy, ndone;
        bit stable;
        int abort_at[2];
        run_op(16'd3, 16'd5, lat, nbusy, stable);
        tick();
        abort_at[0] = 8;
        abort_at[1] = N;
        for (int r = 0; r < 2; r++) begin
            start = 1'b1; rs1 = 16'd10; rs2 = 16'd10;
            tick();
            start = 1'b0;
            for (int k = 1; k < abort_at[r]; k++) tick();
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_%0d_busy_before: got %b want 1", r, busy); end
            abort = 1'b1;
            start = 1'b1;
            tick();
            abort = 1'b0;
            start = 1'b0;
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++; $display("FAIL abort_%0d_state: busy=%b done=%b want 0 0", r, busy, done);
            end
            ndone = 0;
            for (int k = 0; k < 25; k++) begin
                if (done || busy) ndone++;
                tick();
            end
            n_checks++;
            if (ndone !== 0) begin n_fail++; $display("FAIL abort_%0d_quiet: got %0d active cycles want 0", r, ndone); end
            n_checks++;
            if (mul_rd !== 32'd15) begin n_fail++; $display("FAIL abort_%0d_hold: got %0d want 15", r, mul_rd); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, nbusy;
        bit stable;
        start = 1'b1; rs1 = 16'd50; rs2 = 16'd60;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mul_rd !== '0) begin
            n_fail++; $display("FAIL mid_reset: busy=%b done=%b mul_rd=%h want 0 0 0", busy, done, mul_rd);
        end
        run_op(16'd50, 16'd60, lat, nbusy, stable);
        n_checks++;
        if (mul_rd !== 32'd3000 || lat !== N) begin
            n_fail++; $display("FAIL post_reset_op: got %0d lat %0d want 3000 lat %0d", mul_rd, lat, N);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        int lat, nbusy, gap;
        bit stable;
        for (int i = 0; i < 40; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            case ($urandom_range(0, 7))
                0: a = '0;
                1: b = '1;
                2: a = '1;
                3: b = N'(1) << $urandom_range(0, N - 1);
                default: ;
            endcase
            run_op(a, b, lat, nbusy, stable);
            n_checks++;
            if (mul_rd !== model_mul(a, b) || lat !== N || nbusy !== N || !stable) begin
                n_fail++;
                $display("FAIL rand_%0d: %h*%h got %h lat %0d busy %0d stable %0d want %h lat %0d",
                         i, a, b, mul_rd, lat, nbusy, stable, model_mul(a, b), N);
            end
            gap = $urandom_range(0, 3);
            for (int k = 0; k < gap; k++) tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        rs1      = '0;
        rs2      = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_start_while_busy();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative shift-add multiply sequencer: computes an unsigned N×N → 2N product over N clock cycles using one 2N-bit adder. The product is the same as the combinational `mul` array. It sits beside the ALU as the area-reduced multiply path. It accepts one operation at a time through a start/busy/done handshake and holds the result until the next accepted start.

## Interface
- `N`, default 16: operand width. Must be ≥ 2. The result is 2N bits wide.
- `clk` input, 1 bit: the single clock. Everything is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request. Sampled only when `busy`=0.
- `abort` input, 1 bit: cancels an operation in flight. Ignored unless `busy`=1.
- `rs1` input, N bits: multiplicand. Latched on an accepted start.
- `rs2` input, N bits: multiplier. Latched on an accepted start.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: one-cycle pulse when `mul_rd` has been updated.
- `mul_rd` output, 2N bits: product. Held stable between updates.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- Internal state:
  - Operand registers `a_q` (2N bits, zero-extended `rs1`) and `b_q` (N bits).
  - Accumulator `acc_q` (2N bits).
  - Bit counter `cnt_q`, $clog2(N) bits, counting 0..N-1.
- IDLE or DONE with `start`=1 (accepted start):
  - `a_q`←rs1, `b_q`←rs2, `acc_q`←0, `cnt_q`←0.
  - Next state is RUN.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- RUN, each cycle:
  - If `b_q[0]`=1, then `acc_q`←`acc_q`+`a_q`.
  - `a_q`←`a_q`<<1, `b_q`←`b_q`>>1, `cnt_q`←`cnt_q`+1.
  - When `cnt_q`=N-1: `mul_rd`←final sum (`acc_q`+(`b_q[0]` ? `a_q` : 0)), then go to DONE.
- Arithmetic is unsigned and modulo 2^2N. Overflow cannot occur because the product fits in 2N bits.
- RUN with `abort`=1:
  - Go to IDLE immediately.
  - No `done` pulse; `mul_rd` keeps its previous value.
  - `abort` takes priority over completion when `cnt_q`=N-1.
- `start` while `busy`=1 is ignored. It is not queued, and the latched operands do not change.
- `rs1` and `rs2` are don't-care except on the accepted-start cycle.
- `done`=1 exactly when in DONE.
- `busy`=1 exactly when in RUN.
- `mul_rd` changes only on the RUN→DONE transition (and on reset).

## Timing
- Reset state:
  - State = IDLE, `busy`=0, `done`=0, `mul_rd`=0.
  - `acc_q`, `a_q`, `b_q` and `cnt_q` are all 0.
- Latency:
  - `start` is sampled at edge E0.
  - `busy` is high from E0 through E(N).
  - `done` and the new `mul_rd` are visible in the cycle after E(N), i.e. N cycles after acceptance.
- Throughput:
  - A start presented during the `done` cycle is accepted, giving one product every N+1 cycles.
  - If no start is presented, the FSM returns to IDLE after one DONE cycle.
- Reset mid-operation: `rst` at any edge forces the reset state in the next cycle, including clearing `mul_rd`. `rst` overrides `start` and `abort`.
- `abort` and `start` in the same cycle:
  - In RUN: abort only. The start is ignored because `busy`=1.
  - In IDLE or DONE: start only.
- Operands of 0 still take the full N cycles. There is no early termination.

## Test plan
- N=16, rs1=3, rs2=5, start pulse:
  - `busy`=1 for 16 cycles.
  - `done` pulses once, exactly 16 cycles after acceptance.
  - `mul_rd`=32'd15.
  - `mul_rd` is still 15 twenty cycles later.
- rs1=16'hFFFF, rs2=16'hFFFF → `mul_rd`=32'hFFFE0001. Then rs1=0, rs2=16'h1234 → `mul_rd`=0, with the full 16-cycle latency.
- Back-to-back:
  - Hold `start` high with new operands each time `done`=1: 7×9, then 16'h8000×2, then 1×16'hFFFF.
  - Required results: 63, 32'h00010000, 32'h0000FFFF.
  - `done` pulses 17 cycles apart.
- Start while busy: accept 100×200, then pulse `start` with 1×1 at cycle 5 of RUN → only one `done`, `mul_rd`=20000.
- Abort: after a completed 3×5 (`mul_rd`=15), start 10×10, then assert `abort` at RUN cycle 8 → `busy` drops the next cycle, no `done`, `mul_rd` stays 15. Repeat with `abort` on the final RUN cycle → same outcome.
- Reset: assert `rst` at RUN cycle 10 of 50×60 → next cycle shows `busy`=0, `done`=0, `mul_rd`=0. A fresh start afterwards yields the correct product.
